slink_bist_rx: RTL and testbench

//  BIST checker at the receive end of the S-Link application interface. Mirrors slink_bist_tx.

---
 rtl/slink_bist_rx.sv | 307 ++++++++++++++++++++++++++++++
 tb/tb_slink_bist_rx.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/slink_bist_rx.sv
`default_nettype none
// ============================================================================
//  Module   : slink_bist_rx
//  Purpose  : BIST checker at the receive side of the S-Link application
//             interface, the mirror of slink_bist_tx. It snoops packets
//             leaving LL RX, regenerates the expected header sequence and
//             payload pattern, counts mismatching headers/beats and clean
//             packets, and reports lock status to SW registers.
//  Ports    :
//    clk, reset (async, active-high)
//    swi_bist_en / swi_bist_reset      async SW controls, double-flopped here
//    swi_bist_mode_payload [3:0]       payload pattern select
//    swi_bist_mode_wc / _di            expect incrementing word_count / data_id
//    swi_bist_wc_min/max [15:0], swi_bist_di_min/max [7:0], swi_bist_seed [31:0]
//    sop, data_id[7:0], word_count[15:0]   LL RX header
//    valid, app_data[W-1:0]                LL RX payload beat (byte0 in [7:0])
//    bist_locked, bist_errors[15:0], bist_packets[15:0]
//    bist_err_exp/bist_err_act [W-1:0]     first-error beat capture
//  Config   : define SLINK_BIST_RX_ERR_CAPTURE_EN to build the first-error
//             capture registers; otherwise bist_err_exp/act are tied to 0.
//  Revision : 1.0 - initial release
// ============================================================================
module slink_bist_rx #(
  parameter int APP_DATA_WIDTH = 32,
  parameter int APP_DATA_BYTES = APP_DATA_WIDTH >> 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      swi_bist_en,
  input  logic                      swi_bist_reset,
  input  logic [3:0]                swi_bist_mode_payload,
  input  logic                      swi_bist_mode_wc,
  input  logic                      swi_bist_mode_di,
  input  logic [15:0]               swi_bist_wc_min,
  input  logic [15:0]               swi_bist_wc_max,
  input  logic [7:0]                swi_bist_di_min,
  input  logic [7:0]                swi_bist_di_max,
  input  logic [31:0]               swi_bist_seed,
  input  logic                      sop,
  input  logic [7:0]                data_id,
  input  logic [15:0]               word_count,
  input  logic                      valid,
  input  logic [APP_DATA_WIDTH-1:0] app_data,
  output logic                      bist_locked,
  output logic [15:0]               bist_errors,
  output logic [15:0]               bist_packets,
  output logic [APP_DATA_WIDTH-1:0] bist_err_exp,
  output logic [APP_DATA_WIDTH-1:0] bist_err_act
);

  // Payload pattern encodings shared with slink_bist_tx
  localparam logic [3:0]  c_payload_1010  = 4'd0;
  localparam logic [3:0]  c_payload_1100  = 4'd1;
  localparam logic [3:0]  c_payload_f0    = 4'd2;
  localparam logic [3:0]  c_payload_count = 4'd3;
  localparam logic [3:0]  c_payload_prbs9 = 4'd4;
  localparam logic [16:0] c_beat_bytes    = 17'(APP_DATA_BYTES);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_SOP = 2'd1,
    ST_PAYLOAD  = 2'd2
  } state_t;

  // One PRBS9 (x^9 + x^5 + 1) byte step: returns {next_reg, data_byte},
  // first generated bit lands in data bit 0.
  function automatic logic [16:0] prbs9_byte(input logic [8:0] prev);
    logic [8:0] r;
    logic [7:0] d;
    r = prev;
    d = '0;
    for (int b = 0; b < 8; b++) begin
      d[b] = r[8] ^ r[4];
      r    = {r[7:0], d[b]};
    end
    return {r, d};
  endfunction

  // --------------------------------------------------------------------------
  // SW control synchronisers
  // --------------------------------------------------------------------------
  logic r_en_ff1, r_en_ff2, r_rst_ff1, r_rst_ff2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_en_ff1  <= 1'b0;
      r_en_ff2  <= 1'b0;
      r_rst_ff1 <= 1'b0;
      r_rst_ff2 <= 1'b0;
    end else begin
      r_en_ff1  <= swi_bist_en;
      r_en_ff2  <= r_en_ff1;
      r_rst_ff1 <= swi_bist_reset;
      r_rst_ff2 <= r_rst_ff1;
    end
  end

  // --------------------------------------------------------------------------
  // Checker state
  // --------------------------------------------------------------------------
  state_t      r_state, w_state_nxt;
  logic [7:0]  r_exp_di;
  logic [15:0] r_exp_wc;
  logic [15:0] r_pkt_wc;
  logic [15:0] r_byte_cnt;
  logic [8:0]  r_prbs;
  logic        r_pkt_err;
  logic        r_locked;
  logic [15:0] r_errors;
  logic [15:0] r_packets;

  // A header arriving this cycle redefines the packet length and restarts
  // the byte count, so a same-cycle beat is checked against the new header.
  logic [15:0] w_wc, w_bcnt;
  assign w_wc   = sop ? word_count : r_pkt_wc;
  assign w_bcnt = sop ? 16'd0      : r_byte_cnt;

  // Expected beat and per-byte mismatch (only bytes inside word_count)
  logic [APP_DATA_WIDTH-1:0] w_exp_beat;
  logic [APP_DATA_BYTES-1:0] w_byte_bad;
  logic [8:0]                w_prbs_chain;
  logic [16:0]               w_prbs_step;
  logic [16:0]               w_pos;
  logic [7:0]                w_exp_byte;

  always_comb begin
    w_prbs_chain = r_prbs;
    w_prbs_step  = '0;
    w_pos        = '0;
    w_exp_byte   = '0;
    w_exp_beat   = '0;
    w_byte_bad   = '0;
    for (int i = 0; i < APP_DATA_BYTES; i++) begin
      w_pos = {1'b0, w_bcnt} + 17'(i);
      case (swi_bist_mode_payload)
        c_payload_1010:  w_exp_byte = 8'hAA;
        c_payload_1100:  w_exp_byte = 8'hCC;
        c_payload_f0:    w_exp_byte = 8'hF0;
        c_payload_count: w_exp_byte = w_pos[7:0];
        c_payload_prbs9: begin
          // Chain runs over every byte of the beat, including ignored tail
          // bytes, so it stays in step with the transmitter.
          w_prbs_step  = prbs9_byte(w_prbs_chain);
          w_exp_byte   = w_prbs_step[7:0];
          w_prbs_chain = w_prbs_step[16:8];
        end
        default:         w_exp_byte = 8'hD0;
      endcase
      w_exp_beat[8*i +: 8] = w_exp_byte;
      w_byte_bad[i] = (w_pos < {1'b0, w_wc}) && (app_data[8*i +: 8] != w_exp_byte);
    end
  end

  // --------------------------------------------------------------------------
  // FSM: state register + next-state / event decode
  // --------------------------------------------------------------------------
  logic w_init, w_hdr, w_hdr_err, w_beat, w_beat_err, w_trunc, w_stray;
  logic w_pkt_done, w_pkt_bad, w_err_any;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_init      = 1'b0;
    w_hdr       = 1'b0;
    w_hdr_err   = 1'b0;
    w_beat      = 1'b0;
    w_beat_err  = 1'b0;
    w_trunc     = 1'b0;
    w_stray     = 1'b0;
    w_pkt_done  = 1'b0;
    w_pkt_bad   = r_pkt_err;
    if (r_rst_ff2 || !r_en_ff2) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_state_nxt = ST_WAIT_SOP;
          w_init      = 1'b1;
        end
        ST_WAIT_SOP, ST_PAYLOAD: begin
          if (sop) begin
            w_trunc   = (r_state == ST_PAYLOAD);
            w_hdr     = 1'b1;
            w_hdr_err = (data_id != r_exp_di) || (word_count != r_exp_wc);
            w_pkt_bad = w_hdr_err;
            if (word_count == 16'd0) begin
              w_pkt_done  = 1'b1;
              w_state_nxt = ST_WAIT_SOP;
              w_stray     = valid;
            end else begin
              w_state_nxt = ST_PAYLOAD;
              w_beat      = valid;
            end
          end else if (r_state == ST_PAYLOAD) begin
            w_beat = valid;
          end else begin
            w_stray = valid;
          end
          if (w_beat) begin
            w_beat_err = |w_byte_bad;
            w_pkt_bad  = w_pkt_bad | w_beat_err;
            if (({1'b0, w_bcnt} + c_beat_bytes) >= {1'b0, w_wc}) begin
              w_pkt_done  = 1'b1;
              w_state_nxt = ST_WAIT_SOP;
            end
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
    // At most one error count per cycle whatever combination occurred
    w_err_any = w_hdr_err | w_trunc | w_stray | w_beat_err;
  end

  // --------------------------------------------------------------------------
  // Datapath: expected header sequence, packet tracking, counters
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_exp_di   <= '0;
      r_exp_wc   <= '0;
      r_pkt_wc   <= '0;
      r_byte_cnt <= '0;
      r_prbs     <= '0;
      r_pkt_err  <= 1'b0;
      r_locked   <= 1'b0;
      r_errors   <= '0;
      r_packets  <= '0;
    end else if (r_rst_ff2) begin
      r_pkt_err  <= 1'b0;
      r_locked   <= 1'b0;
      r_errors   <= '0;
      r_packets  <= '0;
    end else begin
      if (w_init) begin
        r_exp_di <= swi_bist_di_min;
        r_exp_wc <= swi_bist_wc_min;
        r_prbs   <= swi_bist_seed[8:0];
      end
      if (w_hdr) begin
        r_pkt_wc   <= word_count;
        r_byte_cnt <= '0;
      end
      if (w_beat) begin
        r_byte_cnt <= w_bcnt + c_beat_bytes[15:0];
        r_prbs     <= w_prbs_chain;
      end
      if (w_hdr || w_beat) r_pkt_err <= w_pkt_bad;
      if (w_err_any && (r_errors != 16'hFFFF)) r_errors <= r_errors + 16'd1;
      if (w_pkt_done) begin
        if (!w_pkt_bad) begin
          r_locked <= 1'b1;
          if (r_packets != 16'hFFFF) r_packets <= r_packets + 16'd1;
        end
        if (swi_bist_mode_di)
          r_exp_di <= (r_exp_di == swi_bist_di_max) ? swi_bist_di_min : r_exp_di + 8'd1;
        if (swi_bist_mode_wc)
          r_exp_wc <= (r_exp_wc == swi_bist_wc_max) ? swi_bist_wc_min : r_exp_wc + 16'd1;
      end
    end
  end

  assign bist_locked  = r_locked;
  assign bist_errors  = r_errors;
  assign bist_packets = r_packets;

  logic w_unused_seed;
  assign w_unused_seed = ^swi_bist_seed[31:9];

  // --------------------------------------------------------------------------
  // First-error capture
  // --------------------------------------------------------------------------
`ifdef SLINK_BIST_RX_ERR_CAPTURE_EN
  logic                      r_cap_valid;
  logic [APP_DATA_WIDTH-1:0] r_cap_exp, r_cap_act;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cap_valid <= 1'b0;
      r_cap_exp   <= '0;
      r_cap_act   <= '0;
    end else if (r_rst_ff2) begin
      r_cap_valid <= 1'b0;
      r_cap_exp   <= '0;
      r_cap_act   <= '0;
    end else if (w_beat_err && !r_cap_valid) begin
      r_cap_valid <= 1'b1;
      r_cap_exp   <= w_exp_beat;
      r_cap_act   <= app_data;
    end
  end

  assign bist_err_exp = r_cap_exp;
  assign bist_err_act = r_cap_act;
`else
  logic w_unused_cap;
  assign w_unused_cap = ^w_exp_beat;
  assign bist_err_exp = '0;
  assign bist_err_act = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_slink_bist_rx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_slink_bist_rx
//  Purpose  : Self-checking bench for slink_bist_rx (W=32). A behavioural
//             transmitter drives packets; expected counter values are pushed
//             to a scoreboard and compared against the checker outputs.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_slink_bist_rx;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         swi_bist_en, swi_bist_reset;
  logic [3:0]   swi_bist_mode_payload;
  logic         swi_bist_mode_wc, swi_bist_mode_di;
  logic [15:0]  swi_bist_wc_min, swi_bist_wc_max;
  logic [7:0]   swi_bist_di_min, swi_bist_di_max;
  logic [31:0]  swi_bist_seed;
  logic         sop, valid;
  logic [7:0]   data_id;
  logic [15:0]  word_count;
  logic [W-1:0] app_data;
  logic         bist_locked;
  logic [15:0]  bist_errors, bist_packets;
  logic [W-1:0] bist_err_exp, bist_err_act;

  always #5 clk = ~clk;

  slink_bist_rx #(.APP_DATA_WIDTH(W)) dut (
    .clk                   (clk),
    .reset                 (reset),
    .swi_bist_en           (swi_bist_en),
    .swi_bist_reset        (swi_bist_reset),
    .swi_bist_mode_payload (swi_bist_mode_payload),
    .swi_bist_mode_wc      (swi_bist_mode_wc),
    .swi_bist_mode_di      (swi_bist_mode_di),
    .swi_bist_wc_min       (swi_bist_wc_min),
    .swi_bist_wc_max       (swi_bist_wc_max),
    .swi_bist_di_min       (swi_bist_di_min),
    .swi_bist_di_max       (swi_bist_di_max),
    .swi_bist_seed         (swi_bist_seed),
    .sop                   (sop),
    .data_id               (data_id),
    .word_count            (word_count),
    .valid                 (valid),
    .app_data              (app_data),
    .bist_locked           (bist_locked),
    .bist_errors           (bist_errors),
    .bist_packets          (bist_packets),
    .bist_err_exp          (bist_err_exp),
    .bist_err_act          (bist_err_act)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [15:0] id;
    logic [15:0] err;
    logic [15:0] pkts;
    logic        lock;
  } sb_t;

  sb_t         sb_q[$];
  int          sb_id = 0;
  logic [15:0] m_err, m_pkts;
  logic        m_lock;
  logic [8:0]  tb_prbs;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic sb_push();
    sb_t s;
    s.id   = 16'(sb_id);
    s.err  = m_err;
    s.pkts = m_pkts;
    s.lock = m_lock;
    sb_q.push_back(s);
    sb_id++;
  endtask

  task automatic sb_drain();
    sb_t s;
    while (sb_q.size() > 0) begin
      s = sb_q.pop_front();
      check_val($sformatf("errors#%0d", s.id),  {16'h0, bist_errors},  {16'h0, s.err});
      check_val($sformatf("packets#%0d", s.id), {16'h0, bist_packets}, {16'h0, s.pkts});
      check_val($sformatf("locked#%0d", s.id),  {31'h0, bist_locked},  {31'h0, s.lock});
    end
  endtask

  task automatic bump_err();
    if (m_err != 16'hFFFF) m_err = m_err + 16'd1;
  endtask

  task automatic good_pkt();
    if (m_pkts != 16'hFFFF) m_pkts = m_pkts + 16'd1;
    m_lock = 1'b1;
  endtask

  // Reference PRBS9 (x^9 + x^5 + 1), one byte: {next_state, byte}
  function automatic logic [16:0] tb_prbs9(input logic [8:0] s);
    logic [8:0] r;
    logic [7:0] d;
    r = s;
    d = '0;
    for (int k = 0; k < 8; k++) begin
      d[k] = r[8] ^ r[4];
      r    = {r[7:0], d[k]};
    end
    return {r, d};
  endfunction

  // SW clear: hold through the synchroniser, then let the checker reseed
  task automatic bist_clear();
    swi_bist_reset = 1'b1;
    repeat (3) tick();
    swi_bist_reset = 1'b0;
    repeat (4) tick();
    tb_prbs = swi_bist_seed[8:0];
    m_err   = '0;
    m_pkts  = '0;
    m_lock  = 1'b0;
  endtask

  // Transmit one packet. Sends at most max_beats beats; beat bad_beat is
  // XORed with flip. Bytes beyond word_count are random garbage.
  task automatic send_pkt(input logic [7:0] di, input logic [15:0] wc, input int max_beats,
                          input int bad_beat, input logic [31:0] flip, input bit same_cycle);
    int          tot, nb, pos;
    logic [31:0] beat;
    logic [16:0] pb;
    tot = (int'(wc) + 3) / 4;
    nb  = (max_beats < tot) ? max_beats : tot;
    sop        = 1'b1;
    data_id    = di;
    word_count = wc;
    if (!same_cycle) begin
      tick();
      sop = 1'b0;
    end
    for (int b = 0; b < nb; b++) begin
      for (int i = 0; i < 4; i++) begin
        pos = b * 4 + i;
        case (swi_bist_mode_payload)
          4'd0: beat[8*i +: 8] = 8'hAA;
          4'd1: beat[8*i +: 8] = 8'hCC;
          4'd2: beat[8*i +: 8] = 8'hF0;
          4'd3: beat[8*i +: 8] = pos[7:0];
          4'd4: begin
            pb = tb_prbs9(tb_prbs);
            beat[8*i +: 8] = pb[7:0];
            tb_prbs = pb[16:8];
          end
          default: beat[8*i +: 8] = 8'hD0;
        endcase
        if (pos >= int'(wc)) beat[8*i +: 8] = 8'($urandom_range(0, 255));
      end
      app_data = (b == bad_beat) ? (beat ^ flip) : beat;
      valid    = 1'b1;
      tick();
      sop   = 1'b0;
      valid = 1'b0;
    end
    sop      = 1'b0;
    valid    = 1'b0;
    app_data = '0;
  endtask

  logic [7:0]  mdi;
  logic [15:0] mwc;
  logic [31:0] cap_exp, cap_act;

  initial begin
    reset = 1'b1;
    swi_bist_en = 1'b0;  swi_bist_reset = 1'b0;
    swi_bist_mode_payload = 4'd3;
    swi_bist_mode_wc = 1'b0; swi_bist_mode_di = 1'b0;
    swi_bist_wc_min = 16'd8; swi_bist_wc_max = 16'd8;
    swi_bist_di_min = 8'h12; swi_bist_di_max = 8'h12;
    swi_bist_seed = 32'h0000_01FF;
    sop = 1'b0; valid = 1'b0; data_id = '0; word_count = '0; app_data = '0;
    m_err = '0; m_pkts = '0; m_lock = 1'b0;
    tb_prbs = 9'h1FF;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // Reset state
    sb_push();
    sb_drain();
    check_val("rst_err_exp", bist_err_exp, 32'h0);
    check_val("rst_err_act", bist_err_act, 32'h0);

    // COUNT, wc 8, di 0x12: 10 clean packets
    swi_bist_en = 1'b1;
    repeat (5) tick();
    for (int p = 0; p < 10; p++) begin
      send_pkt(8'h12, 16'd8, 99, -1, 32'h0, 1'b0);
      good_pkt();
      sb_push();
      sb_drain();
    end

    // 1010, bit 3 of byte 2 flipped in beat 1 of packet 4
    swi_bist_mode_payload = 4'd0;
    bist_clear();
    sb_push();
    sb_drain();
    for (int p = 0; p < 10; p++) begin
      send_pkt(8'h12, 16'd8, 99, (p == 3) ? 1 : -1, 32'h0008_0000, 1'b0);
      if (p == 3) bump_err();
      else        good_pkt();
      sb_push();
      sb_drain();
    end
`ifdef SLINK_BIST_RX_ERR_CAPTURE_EN
    cap_exp = 32'hAAAA_AAAA;
    cap_act = 32'hAAAA_AAAA ^ 32'h0008_0000;
`else
    cap_exp = 32'h0;
    cap_act = 32'h0;
`endif
    check_val("cap_exp", bist_err_exp, cap_exp);
    check_val("cap_act", bist_err_act, cap_act);

    // wc 5: garbage tail ignored; then wrong data_id
    swi_bist_mode_payload = 4'd3;
    swi_bist_wc_min = 16'd5; swi_bist_wc_max = 16'd5;
    bist_clear();
    send_pkt(8'h12, 16'd5, 99, -1, 32'h0, 1'b0);
    good_pkt();
    sb_push();
    sb_drain();
    send_pkt(8'h13, 16'd5, 99, -1, 32'h0, 1'b0);
    bump_err();
    sb_push();
    sb_drain();

    // Truncation, stray beat, sop+valid in the same cycle
    swi_bist_wc_min = 16'd12; swi_bist_wc_max = 16'd12;
    bist_clear();
    send_pkt(8'h12, 16'd12, 1, -1, 32'h0, 1'b0);
    send_pkt(8'h12, 16'd12, 99, -1, 32'h0, 1'b0);
    bump_err();
    good_pkt();
    sb_push();
    sb_drain();
    app_data = 32'($urandom);
    valid    = 1'b1;
    tick();
    valid    = 1'b0;
    bump_err();
    sb_push();
    sb_drain();
    send_pkt(8'h12, 16'd12, 99, -1, 32'h0, 1'b1);
    good_pkt();
    sb_push();
    sb_drain();

    // PRBS9 loopback: wc 1..20 and di 0x10..0x13 incrementing
    swi_bist_mode_payload = 4'd4;
    swi_bist_seed = 32'h0000_01FF;
    swi_bist_mode_wc = 1'b1; swi_bist_mode_di = 1'b1;
    swi_bist_wc_min = 16'd1;  swi_bist_wc_max = 16'd20;
    swi_bist_di_min = 8'h10;  swi_bist_di_max = 8'h13;
    bist_clear();
    mdi = 8'h10;
    mwc = 16'd1;
    for (int p = 0; p < 100; p++) begin
      send_pkt(mdi, mwc, 99, -1, 32'h0, 1'b0);
      good_pkt();
      sb_push();
      sb_drain();
      mdi = (mdi == 8'h13)  ? 8'h10 : mdi + 8'd1;
      mwc = (mwc == 16'd20) ? 16'd1 : mwc + 16'd1;
    end

    // Error counter saturation with stray beats
    valid    = 1'b1;
    app_data = 32'h0;
    repeat (65540) tick();
    valid = 1'b0;
    m_err = 16'hFFFF;
    sb_push();
    sb_drain();

    // SW reset mid-packet clears everything; next clean packet relocks
    swi_bist_mode_payload = 4'd3;
    swi_bist_mode_wc = 1'b0; swi_bist_mode_di = 1'b0;
    swi_bist_wc_min = 16'd8;  swi_bist_wc_max = 16'd8;
    swi_bist_di_min = 8'h12;  swi_bist_di_max = 8'h12;
    send_pkt(8'h12, 16'd8, 1, -1, 32'h0, 1'b0);
    bist_clear();
    sb_push();
    sb_drain();
    send_pkt(8'h12, 16'd8, 99, -1, 32'h0, 1'b0);
    good_pkt();
    sb_push();
    sb_drain();

    // Disabled: traffic ignored, counters hold
    swi_bist_en = 1'b0;
    repeat (4) tick();
    send_pkt(8'h55, 16'd8, 99, 0, 32'hFF, 1'b0);
    sb_push();
    sb_drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
